// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store port: RISC-V width codes, FSM states,
// and the byte-lane extract/merge helpers used by the lane aligner.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, RMW, RESP} state_e;

  function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                               input logic [1:0]  lane,
                                               input logic [2:0]  funct3);
    logic [31:0]        sh;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    sh = word >> {lane, 3'b000};
    b  = sh[7:0];
    h  = sh[15:0];
    case (funct3)
      F3_B:    r = 32'(b);
      F3_H:    r = 32'(h);
      F3_W:    r = word;
      F3_BU:   r = {24'b0, sh[7:0]};
      F3_HU:   r = {16'b0, sh[15:0]};
      default: r = '0;
    endcase
    return r;
  endfunction

  // Only the addressed lane(s) of the old word are replaced by LSB-aligned store data.
  function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                             input logic [1:0]  lane,
                                             input logic [2:0]  funct3,
                                             input logic [31:0] wdata);
    logic [31:0] mask;
    logic [4:0]  sh;
    sh = {lane, 3'b000};
    case (funct3[1:0])
      2'b00:   mask = 32'h0000_00FF << sh;
      2'b01:   mask = 32'h0000_FFFF << sh;
      default: mask = '1;
    endcase
    return (word & ~mask) | ((wdata << sh) & mask);
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane alignment: load extension, store merge and alignment check
// for one 32-bit memory word.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merged_o,
  output logic        misaligned_o
);

  assign load_o   = lane_extract(word_i, lane_i, funct3_i);
  assign merged_o = lane_merge(word_i, lane_i, funct3_i, wdata_i);

  always_comb begin
    misaligned_o = 1'b0;
    case (funct3_i[1:0])
      2'b01:   misaligned_o = lane_i[0];
      2'b10:   misaligned_o = |lane_i;
      default: misaligned_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store port onto a word-wide memory with combinational read and synchronous
// write; sub-word stores go through a read-modify-write cycle.
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter  int DEPTH = 256,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [2:0]    req_funct3,
  input  logic [31:0]   req_addr,
  input  logic [31:0]   req_wdata,
  output logic          resp_valid,
  output logic [31:0]   resp_rdata,
  output logic          resp_err,
  output logic [AW-1:0] mem_rd_addr,
  input  logic [31:0]   mem_rd_dout,
  output logic [AW-1:0] mem_wr_addr,
  output logic [31:0]   mem_wr_din,
  output logic          mem_we
);

  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  state_e        state_q, state_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic [31:0]   merge_q, merge_d;
  logic [AW-1:0] waddr_q, waddr_d;

  logic [AW-1:0] widx;
  logic [31:0]   ld_val, merged;
  logic          misaligned, f3_ok, oob, acc_err, we_raw;

  assign widx = req_addr[AW+1:2];
  assign oob  = {2'b00, req_addr[31:2]} >= DEPTH_U;

  always_comb begin
    f3_ok = 1'b0;
    case (req_funct3)
      F3_B, F3_H, F3_W, F3_BU, F3_HU: f3_ok = 1'b1;
      default:                        f3_ok = 1'b0;
    endcase
  end

  assign acc_err = !f3_ok || (req_we && req_funct3[2]) || misaligned || oob;

  lsu_lane_align u_align (
    .word_i      (mem_rd_dout),
    .lane_i      (req_addr[1:0]),
    .funct3_i    (req_funct3),
    .wdata_i     (req_wdata),
    .load_o      (ld_val),
    .merged_o    (merged),
    .misaligned_o(misaligned)
  );

  always_comb begin
    state_d     = state_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    merge_d     = merge_q;
    waddr_d     = waddr_q;
    req_ready   = 1'b0;
    mem_rd_addr = widx;
    mem_wr_addr = widx;
    mem_wr_din  = req_wdata;
    we_raw      = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (acc_err) begin
            state_d = RESP;
            rdata_d = '0;
            err_d   = 1'b1;
          end else if (!req_we) begin
            state_d = RESP;
            rdata_d = ld_val;
            err_d   = 1'b0;
          end else if (req_funct3 == F3_W) begin
            state_d = RESP;
            rdata_d = '0;
            err_d   = 1'b0;
            we_raw  = 1'b1;
          end else begin
            // Response registers keep the previous result until this store completes.
            state_d = RMW;
            merge_d = merged;
            waddr_d = widx;
          end
        end
      end
      RMW: begin
        mem_rd_addr = waddr_q;
        mem_wr_addr = waddr_q;
        mem_wr_din  = merge_q;
        we_raw      = 1'b1;
        state_d     = RESP;
        rdata_d     = '0;
        err_d       = 1'b0;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign mem_we     = we_raw && !rst;
  assign resp_valid = (state_q == RESP) && !rst;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rdata_q <= '0;
      err_q   <= 1'b0;
      merge_q <= '0;
      waddr_q <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      merge_q <= merge_d;
      waddr_q <= waddr_d;
    end
  end

endmodule
